// File: rtl/serial_tx_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
// Imported by both the top level and the bit-period timer.
package serial_tx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;

  // Number of bits on the line for one frame: payload plus optional parity.
  function automatic int frame_bits(input int data_w, input logic parity_en);
    return data_w + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period down-counter: latches the divider at frame start, counts each
// bit from Div down to 0 and flags the final cycle of every bit.
module tx_bit_timer #(
  parameter int DIV_W = serial_tx_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_run,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_cnt;

  assign o_bit_end = i_run && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_period <= i_div;
      r_cnt    <= i_div;
    end else if (i_run) begin
      // Reload from the latched period so a live Div change cannot stretch a frame.
      if (r_cnt == '0) begin
        r_cnt <= r_period;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serializes one DATA_W-bit word per handshake, LSB or MSB first, with an
// optional trailing even-parity bit and a one-cycle Done pulse per frame.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Valid,
  output logic              Ready,
  input  logic [DIV_W-1:0]  Div,
  input  logic              Msb_first,
  input  logic              Parity_en,
  output logic              Tx,
  output logic              Bit_strobe,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  tx_state_t         r_state;
  logic [DATA_W:0]   r_shift;
  logic [CNT_W-1:0]  r_bits_left;
  logic              r_tx;
  logic              r_strobe;
  logic              r_done;

  logic              w_accept;
  logic              w_run;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_data_ord;
  logic [DATA_W:0]   w_frame;
  logic [CNT_W-1:0]  w_last_idx;

  // Put the payload in transmit order so the shifter always drains bit 0 first.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_order
      assign w_data_ord[gi] = Msb_first ? Data_in[DATA_W-1-gi] : Data_in[gi];
    end
  endgenerate

  assign w_frame    = {Parity_en & (^Data_in), w_data_ord};
  assign w_last_idx = CNT_W'(frame_bits(DATA_W, Parity_en) - 1);

  assign Ready      = (r_state == IDLE);
  assign Busy       = (r_state == SHIFT);
  assign w_accept   = Valid && Ready;
  assign w_run      = (r_state == SHIFT);

  assign Tx         = r_tx;
  assign Bit_strobe = r_strobe;
  assign Done       = r_done;

  tx_bit_timer #(
    .DIV_W(DIV_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (Reset_n),
    .i_start  (w_accept),
    .i_div    (Div),
    .i_run    (w_run),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_tx        <= 1'b0;
      r_strobe    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx     <= 1'b0;
          r_strobe <= 1'b0;
          r_done   <= 1'b0;
          if (w_accept) begin
            r_state     <= SHIFT;
            r_tx        <= w_frame[0];
            r_shift     <= w_frame >> 1;
            r_bits_left <= w_last_idx;
            r_strobe    <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_bit_end) begin
            if (r_bits_left == '0) begin
              r_state  <= DONE;
              r_tx     <= 1'b0;
              r_strobe <= 1'b0;
              r_done   <= 1'b1;
              r_shift  <= '0;
            end else begin
              r_tx        <= r_shift[0];
              r_shift     <= r_shift >> 1;
              r_bits_left <= r_bits_left - 1'b1;
              r_strobe    <= 1'b1;
            end
          end else begin
            r_strobe <= 1'b0;
          end
        end
        DONE: begin
          r_state  <= IDLE;
          r_tx     <= 1'b0;
          r_strobe <= 1'b0;
          r_done   <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_tx     <= 1'b0;
          r_strobe <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed frames plus random
// frames compared cycle by cycle against a frame-level reference model.
module tb_serial_pattern_tx;

  logic       clk;
  logic       Reset_n;
  logic [7:0] Data_in;
  logic       Valid;
  logic       Ready;
  logic [7:0] Div;
  logic       Msb_first;
  logic       Parity_en;
  logic       Tx;
  logic       Bit_strobe;
  logic       Busy;
  logic       Done;

  int n_tests = 0;
  int n_fail  = 0;

  serial_pattern_tx #(.DATA_W(8), .DIV_W(8)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .Data_in   (Data_in),
    .Valid     (Valid),
    .Ready     (Ready),
    .Div       (Div),
    .Msb_first (Msb_first),
    .Parity_en (Parity_en),
    .Tx        (Tx),
    .Bit_strobe(Bit_strobe),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Expected {Tx, Bit_strobe, Busy, Done, Ready} in cycle c after acceptance.
  function automatic logic [4:0] model_vec(input logic [7:0] d, input int div,
                                           input bit msb, input bit par, input int c);
    int  n;
    int  per;
    int  k;
    logic b;
    n   = 8 + (par ? 1 : 0);
    per = div + 1;
    if (c >= 1 && c <= n * per) begin
      k = (c - 1) / per;
      if (k == 8) b = ^d;
      else        b = msb ? d[7 - k] : d[k];
      return {b, ((c - 1) % per) == 0, 1'b1, 1'b0, 1'b0};
    end else if (c == n * per + 1) begin
      return 5'b00010;
    end
    return 5'b00001;
  endfunction

  function automatic logic [4:0] dut_vec();
    return {Tx, Bit_strobe, Busy, Done, Ready};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for Ready, then offers one word; returns in cycle 1.
  task automatic accept(input logic [7:0] d, input logic [7:0] dv,
                        input bit m, input bit p, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    while (Ready !== 1'b1 && w < 5000) begin
      step();
      w++;
    end
    if (Ready === 1'b1) begin
      Data_in   = d;
      Div       = dv;
      Msb_first = m;
      Parity_en = p;
      Valid     = 1'b1;
      step();
      Valid     = 1'b0;
      ok        = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [4:0] got;
    Reset_n = 1'b1; Valid = 1'b0; Data_in = '0; Div = '0; Msb_first = 0; Parity_en = 0;
    #2;
    Reset_n   = 1'b0;
    Valid     = 1'b1;
    Data_in   = 8'($urandom);
    repeat (3) step();
    got = dut_vec();
    n_tests++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_hold: got %b, expected %b", got, 5'b00001);
    end
    Valid = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    step();
    got = dut_vec();
    n_tests++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_release: got %b, expected %b", got, 5'b00001);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_lsb_a5();
    bit ok;
    logic [4:0] got, exp;
    logic [7:0] lit;
    lit = 8'b10100101;
    accept(8'hA5, 8'd0, 0, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL a5_accept: got %b, expected 1", ok); end
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      exp = model_vec(8'hA5, 0, 0, 0, c);
      got = dut_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL a5_trace cycle %0d: got %b, expected %b", c, got, exp);
        break;
      end
      if (c <= 8) begin
        n_tests++;
        if (Tx !== lit[8 - c]) begin
          n_fail++;
          $display("FAIL a5_literal cycle %0d: got %b, expected %b", c, Tx, lit[8 - c]);
        end
      end
    end
    $display("[TB] frame data=a5 div=0 lsb-first no parity");
  endtask

  task automatic test_div2_msb();
    bit ok;
    logic [4:0] got, exp;
    int n_ones, first_one, n_stb, last_stb, bad_gap;
    n_ones = 0; first_one = 0; n_stb = 0; last_stb = -3; bad_gap = 0;
    accept(8'h01, 8'd2, 1, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL div2_accept: got %b, expected 1", ok); end
    for (int c = 1; c <= 26; c++) begin
      if (c > 1) step();
      exp = model_vec(8'h01, 2, 1, 0, c);
      got = dut_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL div2_trace cycle %0d: got %b, expected %b", c, got, exp);
        break;
      end
      if (Tx === 1'b1) begin
        if (n_ones == 0) first_one = c;
        n_ones++;
      end
      if (Bit_strobe === 1'b1) begin
        if (n_stb > 0 && c - last_stb != 3) bad_gap++;
        last_stb = c;
        n_stb++;
      end
    end
    n_tests++;
    if (n_ones !== 3 || first_one !== 22) begin
      n_fail++;
      $display("FAIL div2_ones: got %0d ones from cycle %0d, expected 3 from cycle 22", n_ones, first_one);
    end
    n_tests++;
    if (n_stb !== 8 || bad_gap !== 0) begin
      n_fail++;
      $display("FAIL div2_strobes: got %0d strobes (%0d bad gaps), expected 8 (0)", n_stb, bad_gap);
    end
    $display("[TB] frame data=01 div=2 msb-first no parity");
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    logic       pexp  [2];
    bit ok;
    logic [4:0] got, exp;
    logic tx9, done10;
    words[0] = 8'h07; pexp[0] = 1'b1;
    words[1] = 8'h03; pexp[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tx9 = 1'bx; done10 = 1'bx;
      accept(words[w], 8'd0, 0, 1, ok);
      n_tests++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL parity_accept: got %b, expected 1", ok); end
      for (int c = 1; c <= 11; c++) begin
        if (c > 1) step();
        exp = model_vec(words[w], 0, 0, 1, c);
        got = dut_vec();
        if (c == 9)  tx9    = Tx;
        if (c == 10) done10 = Done;
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL parity_trace word %h cycle %0d: got %b, expected %b", words[w], c, got, exp);
          break;
        end
      end
      n_tests++;
      if (tx9 !== pexp[w] || done10 !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_bit word %h: got bit9=%b done10=%b, expected bit9=%b done10=1",
                 words[w], tx9, done10, pexp[w]);
      end
      $display("[TB] frame data=%h div=0 parity", words[w]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [4:0] got, exp;
    accept(8'hFF, 8'd0, 0, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b, expected 1", ok); end
    Valid = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) step();
      exp = (c <= 10) ? model_vec(8'hFF, 0, 0, 0, c) : model_vec(8'h00, 0, 0, 0, c - 10);
      got = dut_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_trace cycle %0d: got %b, expected %b", c, got, exp);
        break;
      end
      if (c <= 8) begin
        Data_in = 8'($urandom); Div = 8'($urandom);
        Msb_first = 1'($urandom); Parity_en = 1'($urandom);
      end else if (c == 9) begin
        Data_in = 8'h00; Div = 8'd0; Msb_first = 0; Parity_en = 0;
      end else if (c == 11) begin
        Valid = 1'b0;
      end
    end
    Valid = 1'b0;
    $display("[TB] frames data=ff then 00 back-to-back");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [4:0] got, exp;
    accept(8'hF0, 8'd0, 0, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got %b, expected 1", ok); end
    repeat (4) step();
    exp = model_vec(8'hF0, 0, 0, 0, 5);
    got = dut_vec();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL midrst_bit4: got %b, expected %b", got, exp);
    end
    #1 Reset_n = 1'b0;
    #1;
    got = dut_vec();
    n_tests++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL midrst_async: got %b, expected %b", got, 5'b00001);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      got = dut_vec();
      n_tests++;
      if (got !== 5'b00001) begin
        n_fail++;
        $display("FAIL midrst_hold cycle %0d: got %b, expected %b", i, got, 5'b00001);
      end
    end
    @(negedge clk);
    Reset_n = 1'b1;
    step();
    got = dut_vec();
    n_tests++;
    if (got !== 5'b00001) begin
      n_fail++;
      $display("FAIL midrst_release: got %b, expected %b", got, 5'b00001);
    end
    accept(8'h81, 8'd0, 1, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_reaccept: got %b, expected 1", ok); end
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      exp = model_vec(8'h81, 0, 1, 0, c);
      got = dut_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL midrst_frame cycle %0d: got %b, expected %b", c, got, exp);
        break;
      end
    end
    $display("[TB] frame data=f0 aborted by reset, then data=81");
  endtask

  task automatic test_config_change();
    bit ok;
    logic [4:0] got, exp;
    logic [7:0] d;
    int dv, n, last;
    bit m, p;
    for (int f = 0; f < 3; f++) begin
      d = 8'($urandom); dv = $urandom_range(0, 3);
      m = 1'($urandom); p = 1'($urandom);
      n = 8 + (p ? 1 : 0);
      last = n * (dv + 1) + 3;
      accept(d, 8'(dv), m, p, ok);
      n_tests++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL cfg_accept: got %b, expected 1", ok); end
      for (int c = 1; c <= last; c++) begin
        if (c > 1) step();
        exp = model_vec(d, dv, m, p, c);
        got = dut_vec();
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL cfg_trace frame %0d cycle %0d: got %b, expected %b", f, c, got, exp);
          break;
        end
        if (c <= n * (dv + 1) + 1) begin
          Data_in = 8'($urandom); Div = 8'($urandom);
          Msb_first = 1'($urandom); Parity_en = 1'($urandom);
          Valid = 1'($urandom);
        end else begin
          Valid = 1'b0;
        end
      end
      Valid = 1'b0;
      $display("[TB] frame data=%h div=%0d msb=%0b par=%0b with live input changes", d, dv, m, p);
    end
  endtask

  task automatic test_div_max();
    bit ok;
    logic [4:0] got, exp;
    logic [7:0] d;
    d = 8'($urandom);
    accept(d, 8'hFF, 0, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL divmax_accept: got %b, expected 1", ok); end
    for (int c = 1; c <= 8 * 256 + 2; c++) begin
      if (c > 1) step();
      exp = model_vec(d, 255, 0, 0, c);
      got = dut_vec();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL divmax_trace cycle %0d: got %b, expected %b", c, got, exp);
        break;
      end
    end
    $display("[TB] frame data=%h div=255", d);
  endtask

  task automatic test_random();
    bit ok;
    logic [4:0] got, exp;
    logic [7:0] d;
    int dv, n;
    bit m, p;
    for (int f = 0; f < 20; f++) begin
      d = 8'($urandom); dv = $urandom_range(0, 7);
      m = 1'($urandom); p = 1'($urandom);
      n = 8 + (p ? 1 : 0);
      repeat ($urandom_range(0, 2)) step();
      accept(d, 8'(dv), m, p, ok);
      n_tests++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_accept: got %b, expected 1", ok); end
      for (int c = 1; c <= n * (dv + 1) + 2; c++) begin
        if (c > 1) step();
        exp = model_vec(d, dv, m, p, c);
        got = dut_vec();
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL rand_trace frame %0d cycle %0d: got %b, expected %b", f, c, got, exp);
          break;
        end
      end
      $display("[TB] frame data=%h div=%0d msb=%0b par=%0b", d, dv, m, p);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_a5();
    test_div2_msb();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    test_config_change();
    test_div_max();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter DIV_W, default 8, meaning the width of the bit-period divider.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit, the reset, asynchronous and active-low.
REQ-005 SHALL have port Data_in, input, DATA_W bits, the word to serialize.
REQ-006 SHALL have port Valid, input, 1 bit, which offers Data_in and the configuration inputs.
REQ-007 SHALL have port Ready, output, 1 bit, which is high exactly when a word can be accepted.
REQ-008 SHALL have port Div, input, DIV_W bits, giving cycles per bit minus 1.
REQ-009 SHALL have port Msb_first, input, 1 bit: 1 = MSB first, 0 = LSB first.
REQ-010 SHALL have port Parity_en, input, 1 bit, which appends an even-parity bit when 1.
REQ-011 SHALL have port Tx, output, 1 bit, the serial line; its idle level is 0.
REQ-012 SHALL have port Bit_strobe, output, 1 bit, a 1-cycle pulse in the first cycle of each bit.
REQ-013 SHALL have port Busy, output, 1 bit, high while bits are being driven.
REQ-014 SHALL have port Done, output, 1 bit, a 1-cycle pulse after the last bit.

Function
REQ-015 SHALL implement states IDLE, SHIFT and DONE; Ready = (state == IDLE).
REQ-016 SHALL accept a word on a rising edge where Valid && Ready is true.
REQ-017 SHALL sample Data_in, Div, Msb_first and Parity_en at acceptance only; later changes are ignored until the next acceptance.
REQ-018 SHALL, on acceptance, go IDLE -> SHIFT and drive the first bit on Tx in the next cycle, with Bit_strobe = 1.
REQ-019 SHALL hold each bit on Tx for exactly Div+1 cycles; Div = 0 gives one bit per cycle; Div = all-ones gives 2^DIV_W cycles.
REQ-020 SHALL send N = DATA_W + Parity_en bits; the parity bit SHALL be the XOR of all data bits and SHALL always be sent last.
REQ-021 SHALL keep Busy = 1 throughout SHIFT and 0 in all other states.
REQ-022 SHALL go SHIFT -> DONE after the last cycle of bit N; DONE lasts one cycle with Done = 1 and Tx = 0, then the block goes DONE -> IDLE unconditionally.
REQ-023 SHALL make Ready high again N*(Div+1)+2 cycles after the accepting edge; back-to-back words therefore have 2 Tx = 0 gap cycles.
REQ-024 SHALL ignore Valid in SHIFT and DONE; a held Valid is accepted in the first IDLE cycle.
REQ-025 SHALL keep Tx, Bit_strobe and Done as registered outputs, so they never glitch from combinational inputs.

Reset
REQ-026 SHALL, while Reset_n = 0, immediately force state to IDLE with Tx = 0, Bit_strobe = 0, Busy = 0, Done = 0 and all counters and the shift register at 0.
REQ-027 SHALL, on reset in mid-frame, abandon the frame without a Done pulse; the first post-release acceptance SHALL start from bit 0.
REQ-028 SHALL set Ready = 1 during and after reset, but SHALL NOT accept any word while Reset_n = 0.

Structure
REQ-029 SHALL define the state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2) and the default DATA_W/DIV_W constants in the shared package serial_tx_pkg.
REQ-030 SHALL place the bit-period down-counter in sub-module tx_bit_timer (load Div, count to 0, emit an end-of-bit pulse); bit count, shift register and FSM stay in serial_pattern_tx.

Verification
REQ-031 SHALL cover: Data_in = 8'hA5, Div = 0, Msb_first = 0, Parity_en = 0 -> Tx = 1,0,1,0,0,1,0,1 in cycles 1-8 after acceptance, Done in cycle 9, Ready in cycle 10.
REQ-032 SHALL cover: 8'h01, Div = 2, Msb_first = 1 -> Tx = 0 for 21 cycles then 1 for 3 cycles, with 8 Bit_strobe pulses spaced 3 cycles apart.
REQ-033 SHALL cover: Parity_en = 1 with 8'h07 -> 9th bit = 1; with 8'h03 -> 9th bit = 0; Done in cycle 10.
REQ-034 SHALL cover: Valid held high with 8'hFF then 8'h00, Div = 0 -> two frames separated by exactly 2 Tx = 0 cycles, with the second word sampled only at its own acceptance.
REQ-035 SHALL cover: Reset_n pulsed low during bit 4 of 8'hF0 -> Tx = 0, Busy = 0, no Done; then 8'h81 after release transmits from bit 0 correctly.
REQ-036 SHALL cover: Data_in/Div changed and Valid toggled during SHIFT -> the frame in progress is unchanged and no extra acceptance occurs.
